// File: rtl/bus_dma_copy_if.sv
// MCU control and arbiter handshake bundle for the bus DMA copy engine.
// Fill-mode fields exist only when DMA_FILL_EN is defined.
interface bus_dma_copy_if #(
  parameter int LEN_W = 8
) ();
  logic             start;
  logic [7:0]       src_addr;
  logic [7:0]       dst_addr;
  logic [LEN_W-1:0] len;
`ifdef DMA_FILL_EN
  logic             fill;
  logic [7:0]       fill_val;
`endif
  logic             bus_req;
  logic             bus_gnt;
  logic             busy;
  logic             done;
  logic             err;

`ifdef DMA_FILL_EN
  modport master (
    output start, src_addr, dst_addr, len,
    output fill, fill_val, bus_gnt,
    input  bus_req, busy, done, err
  );
  modport slave (
    input  start, src_addr, dst_addr, len,
    input  fill, fill_val, bus_gnt,
    output bus_req, busy, done, err
  );
`else
  modport master (
    output start, src_addr, dst_addr, len,
    output bus_gnt,
    input  bus_req, busy, done, err
  );
  modport slave (
    input  start, src_addr, dst_addr, len,
    input  bus_gnt,
    output bus_req, busy, done, err
  );
`endif
endinterface

// File: rtl/bus_dma_copy.sv
// Bus-master byte copy engine on a shared tristate 8-bit bus.
// Optional constant-fill mode is compiled in by defining DMA_FILL_EN.
module bus_dma_copy #(
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  bus_dma_copy_if.slave ctl,
  output wire  [7:0]    o_bus_addr,
  inout  wire  [7:0]    io_bus_data,
  output wire           o_bus_we
);
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD_ADDR,
    S_RD_WAIT,
    S_WRITE,
    S_NEXT,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           w_byte0;
  logic [7:0]       r_src;
  logic [7:0]       r_dst;
  logic [7:0]       r_data;
  logic [LEN_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_fill;
  logic             w_req;
  logic             w_own;
  logic             w_hold;
  logic             w_lost;
  logic             w_wr;
  logic             w_cnt_last;
  logic             w_sample;
  logic             w_accept;
  logic [7:0]       w_addr;

`ifdef DMA_FILL_EN
  logic r_fill;
  assign w_fill = r_fill;
`else
  assign w_fill = 1'b0;
`endif

  assign w_req = (r_state == S_REQ) | (r_state == S_RD_ADDR) |
                 (r_state == S_RD_WAIT) | (r_state == S_WRITE) |
                 (r_state == S_NEXT);
  assign w_hold = w_req & (r_state != S_REQ);
  assign w_own  = w_req & ctl.bus_gnt;
  assign w_lost = w_hold & ~ctl.bus_gnt;
  assign w_wr   = w_own & (r_state == S_WRITE);
  assign w_accept = (r_state == S_IDLE) & ctl.start;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_byte0 = w_fill ? S_WRITE : S_RD_ADDR;

  assign w_sample = ctl.bus_gnt &
    (((r_state == S_RD_WAIT) & w_cnt_last) |
     ((r_state == S_RD_ADDR) & (RD_LAT <= 1)));

  assign w_addr = ((r_state == S_WRITE) | (r_state == S_NEXT)) ?
                  r_dst : r_src;

  // Drivers follow ownership combinationally so a lost grant frees the bus at once
  assign o_bus_addr  = w_own ? w_addr : 8'hzz;
  assign o_bus_we    = w_own ? w_wr : 1'bz;
  assign io_bus_data = w_wr ? r_data : 8'hzz;

  assign ctl.bus_req = w_req;
  assign ctl.busy    = w_req;
  assign ctl.done    = (r_state == S_FIN);
  assign ctl.err     = r_err;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (ctl.start)
          w_next = (ctl.len == '0) ? S_FIN : S_REQ;
      end
      S_REQ: begin
        if (ctl.bus_gnt) w_next = w_byte0;
      end
      S_RD_ADDR: begin
        if (!ctl.bus_gnt) w_next = S_FIN;
        else if (RD_LAT <= 1) w_next = S_WRITE;
        else w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (!ctl.bus_gnt) w_next = S_FIN;
        else if (w_cnt_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = ctl.bus_gnt ? S_NEXT : S_FIN;
      end
      S_NEXT: begin
        if (!ctl.bus_gnt) w_next = S_FIN;
        else if (r_rem == LEN_W'(1)) w_next = S_FIN;
        else w_next = w_byte0;
      end
      S_FIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_data  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
`ifdef DMA_FILL_EN
      r_fill  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src <= ctl.src_addr;
        r_dst <= ctl.dst_addr;
        r_rem <= ctl.len;
        r_err <= 1'b0;
`ifdef DMA_FILL_EN
        r_fill <= ctl.fill;
        if (ctl.fill) r_data <= ctl.fill_val;
`endif
      end
      if (w_lost) r_err <= 1'b1;
      if (r_state == S_RD_ADDR) r_cnt <= CNT_W'(1);
      if (r_state == S_RD_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      if (w_sample) r_data <= io_bus_data;
      if (r_state == S_NEXT) begin
        r_src <= r_src + 8'd1;
        r_dst <= r_dst + 8'd1;
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_bus_dma_copy.sv
// Directed bench for bus_dma_copy with a 128-byte two-cycle-read RAM model.
// Fill-mode steps are included when DMA_FILL_EN is defined.
module tb_bus_dma_copy;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic gnt_en = 1'b1;
  int checks = 0;
  int errors = 0;

  wire [7:0] bus_addr;
  tri  [7:0] bus_data;
  wire       bus_we;

  pullup (bus_addr);
  pullup (bus_we);

  bus_dma_copy_if #(.LEN_W(8)) dif ();

  bus_dma_copy #(.LEN_W(8), .RD_LAT(2)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .ctl        (dif),
    .o_bus_addr (bus_addr),
    .io_bus_data(bus_data),
    .o_bus_we   (bus_we)
  );

  always #5 clk = ~clk;

  assign dif.bus_gnt = gnt_en & dif.bus_req;

  logic [7:0] ram [0:127];
  logic       h_we = 1'b0;
  logic [6:0] h_a = '0;
  logic [7:0] h_d = '0;
  logic [7:0] r_a1 = '0;
  logic       r_v1 = 1'b0;
  logic       r_lg = 1'b0;
  logic [7:0] rd_log [0:63];
  logic [7:0] wa_log [0:63];
  logic [7:0] wd_log [0:63];
  int         rd_n = 0;
  int         wr_n = 0;

  wire own = dif.bus_req & dif.bus_gnt;
  wire rd_phase = own & (bus_we === 1'b0);
  wire rd_drv = r_v1 & rd_phase;
  wire rd_hit = rd_drv & (bus_addr == r_a1);
  wire [7:0] rd_val = r_a1[7] ? 8'h00 : ram[r_a1[6:0]];

  assign bus_data = rd_drv ? rd_val : 8'hzz;

  always @(posedge clk) begin
    r_v1 <= rd_phase;
    r_a1 <= bus_addr;
    r_lg <= rd_hit;
    if (rd_hit && !r_lg) begin
      rd_log[rd_n % 64] <= bus_addr;
      rd_n <= rd_n + 1;
    end
    if (own && bus_we === 1'b1) begin
      wa_log[wr_n % 64] <= bus_addr;
      wd_log[wr_n % 64] <= bus_data;
      wr_n <= wr_n + 1;
      if (!bus_addr[7]) ram[bus_addr[6:0]] <= bus_data;
    end
    if (h_we) ram[h_a] <= h_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_wr(input logic [6:0] a, input logic [7:0] d);
    h_we = 1'b1;
    h_a = a;
    h_d = d;
    tick();
    h_we = 1'b0;
  endtask

  task automatic go(input logic [7:0] s, input logic [7:0] d,
                    input logic [7:0] n);
    dif.start = 1'b1;
    dif.src_addr = s;
    dif.dst_addr = d;
    dif.len = n;
    tick();
    dif.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (!dif.done && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;
  int rd0;
  int wr0;
  logic [7:0] exp_b [0:3];

  initial begin
    exp_b[0] = 8'hA1;
    exp_b[1] = 8'hB2;
    exp_b[2] = 8'hC3;
    exp_b[3] = 8'hD4;
    dif.start = 1'b0;
    dif.src_addr = '0;
    dif.dst_addr = '0;
    dif.len = '0;
`ifdef DMA_FILL_EN
    dif.fill = 1'b0;
    dif.fill_val = '0;
`endif
    repeat (2) tick();
    @(negedge clk);
    chk("rst_req", dif.bus_req, 1'b0);
    chk("rst_busy", dif.busy, 1'b0);
    chk("rst_done", dif.done, 1'b0);
    chk("rst_err", dif.err, 1'b0);
    chk("rst_addr_z", bus_addr, 8'hFF);
    chk("rst_we_z", bus_we, 1'b1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) ram_wr(7'(8'h10 + i), exp_b[i]);
    ram_wr(7'h00, 8'h3C);
    ram_wr(7'h7E, 8'hEE);
    ram_wr(7'h7F, 8'hEE);
    ram_wr(7'h50, 8'h77);
    ram_wr(7'h51, 8'h99);
    ram_wr(7'h70, 8'h55);

    // Plain 4-byte copy with grant held
    rd0 = rd_n;
    go(8'h10, 8'h40, 8'd4);
    chk("cp_busy", dif.busy, 1'b1);
    chk("cp_req", dif.bus_req, 1'b1);
    wait_done(n);
    chk("cp_done_lat", n, 17);
    chk("cp_err", dif.err, 1'b0);
    chk("cp_busy_fin", dif.busy, 1'b0);
    chk("cp_req_fin", dif.bus_req, 1'b0);
    tick();
    @(negedge clk);
    chk("cp_done_once", dif.done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("cp_ram", ram[7'h40 + 7'(i)], exp_b[i]);
      chk("cp_rd_addr", rd_log[(rd0 + i) % 64], 8'h10 + 8'(i));
    end
    chk("cp_rd_cnt", rd_n - rd0, 4);

    // Zero-length start
    tick();
    go(8'h10, 8'h40, 8'd0);
    @(negedge clk);
    chk("z_done", dif.done, 1'b1);
    chk("z_req", dif.bus_req, 1'b0);
    chk("z_busy", dif.busy, 1'b0);
    tick();
    @(negedge clk);
    chk("z_done_once", dif.done, 1'b0);
    chk("z_req2", dif.bus_req, 1'b0);
    chk("z_busy2", dif.busy, 1'b0);

    // Address wrap on source, out-of-range destination
    tick();
    rd0 = rd_n;
    wr0 = wr_n;
    go(8'hFE, 8'h7E, 8'd3);
    wait_done(n);
    chk("wr_done_lat", n, 13);
    tick();
    chk("wr_rd0", rd_log[rd0 % 64], 8'hFE);
    chk("wr_rd1", rd_log[(rd0 + 1) % 64], 8'hFF);
    chk("wr_rd2", rd_log[(rd0 + 2) % 64], 8'h00);
    chk("wr_wa0", wa_log[wr0 % 64], 8'h7E);
    chk("wr_wa1", wa_log[(wr0 + 1) % 64], 8'h7F);
    chk("wr_wa2", wa_log[(wr0 + 2) % 64], 8'h80);
    chk("wr_wd2", wd_log[(wr0 + 2) % 64], 8'h3C);
    chk("wr_ram7e", ram[7'h7E], 8'h00);
    chk("wr_ram7f", ram[7'h7F], 8'h00);
    chk("wr_ram00", ram[7'h00], 8'h3C);

    // Grant dropped in the second byte's read wait
    go(8'h10, 8'h50, 8'd4);
    repeat (6) tick();
    chk("gl_pre_we", bus_we, 1'b0);
    chk("gl_pre_addr", bus_addr, 8'h11);
    gnt_en = 1'b0;
    #1;
    chk("gl_addr_z", bus_addr, 8'hFF);
    chk("gl_we_z", bus_we, 1'b1);
    tick();
    chk("gl_done", dif.done, 1'b1);
    chk("gl_err", dif.err, 1'b1);
    chk("gl_busy", dif.busy, 1'b0);
    gnt_en = 1'b1;
    tick();
    chk("gl_done_once", dif.done, 1'b0);
    chk("gl_err_sticky", dif.err, 1'b1);
    chk("gl_ram50", ram[7'h50], 8'hA1);
    chk("gl_ram51", ram[7'h51], 8'h99);

    // New start clears ERR; a START while busy is ignored
    wr0 = wr_n;
    go(8'h12, 8'h60, 8'd2);
    chk("rs_err_clr", dif.err, 1'b0);
    tick();
    dif.start = 1'b1;
    dif.src_addr = 8'h00;
    dif.dst_addr = 8'h70;
    dif.len = 8'd9;
    tick();
    dif.start = 1'b0;
    wait_done(n);
    chk("rs_done_lat", n, 7);
    tick();
    chk("rs_ram60", ram[7'h60], 8'hC3);
    chk("rs_ram61", ram[7'h61], 8'hD4);
    chk("rs_ram70", ram[7'h70], 8'h55);
    chk("rs_wr_cnt", wr_n - wr0, 2);

    // Reset asserted during the second write strobe
    go(8'h10, 8'h30, 8'd4);
    repeat (7) tick();
    chk("rm_we", bus_we, 1'b1);
    chk("rm_addr", bus_addr, 8'h31);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rm_req", dif.bus_req, 1'b0);
    chk("rm_busy", dif.busy, 1'b0);
    chk("rm_addr_z", bus_addr, 8'hFF);
    chk("rm_we_z", bus_we, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("rm_no_done", dif.done, 1'b0);
      @(negedge clk);
    end
    tick();
    go(8'h10, 8'h30, 8'd4);
    chk("rm2_err", dif.err, 1'b0);
    wait_done(n);
    chk("rm2_done_lat", n, 17);
    chk("rm2_err_fin", dif.err, 1'b0);
    tick();
    for (int i = 0; i < 4; i++)
      chk("rm2_ram", ram[7'h30 + 7'(i)], exp_b[i]);

`ifdef DMA_FILL_EN
    // Fill mode: constant writes, no reads
    rd0 = rd_n;
    dif.fill = 1'b1;
    dif.fill_val = 8'h5A;
    go(8'h10, 8'h20, 8'd5);
    dif.fill = 1'b0;
    wait_done(n);
    chk("fl_done_lat", n, 11);
    tick();
    chk("fl_rd_cnt", rd_n - rd0, 0);
    for (int i = 0; i < 5; i++)
      chk("fl_ram", ram[7'h20 + 7'(i)], 8'h5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bus_dma_copy.md
Name: bus_dma_copy

Overview:
- Bus-master copy engine upstream of the 8-bit bus RAM peripheral.
- Moves a block of bytes between bus addresses using the shared BUS_ADDR / BUS_DATA / BUS_WE bus.
- Obtains bus ownership from the system arbiter via BUS_REQ/BUS_GNT.
- Started by the MCU through dedicated control inputs; reports completion via DONE/ERR.

Parameters:
- LEN_W, 8, width of the transfer-length input (max 2^LEN_W-1 bytes).
- RD_LAT, 2, cycles from read address presented to data valid on BUS_DATA (matches registered RAM read-enable plus block-RAM output register).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; latches SRC_ADDR/DST_ADDR/LEN; ignored while BUSY.
- SRC_ADDR  in  8  first source bus address.
- DST_ADDR  in  8  first destination bus address.
- LEN  in  LEN_W  byte count.
- BUS_REQ  out  1  bus request to arbiter.
- BUS_GNT  in  1  bus grant from arbiter.
- BUS_ADDR  out  8  bus address, tristated (8'hZZ) when not owner.
- BUS_DATA  inout  8  driven only during write cycles, else 8'hZZ.
- BUS_WE  out  1  write enable, tristated when not owner.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse at end of transfer (success or error).
- ERR  out  1  sticky; set when grant is lost mid-transfer; cleared by next accepted START.

Behaviour:
- Reset values: BUS_REQ=0, BUSY=0, DONE=0, ERR=0, state=IDLE, all bus drivers released (Z).
- Bus ownership: own = BUS_REQ & BUS_GNT. BUS_ADDR and BUS_WE are driven only while own; BUS_WE is 0 in every owned cycle except WRITE.
- States:
  - IDLE: START with LEN!=0 -> REQ, with BUSY=1 and ERR cleared. START with LEN==0 -> DONE pulse next cycle, no bus request, BUSY stays 0.
  - REQ: BUS_REQ=1; on BUS_GNT -> RD_ADDR.
  - RD_ADDR: drive BUS_ADDR=src, BUS_WE=0; hold the address for RD_LAT cycles (RD_WAIT counter).
  - RD_WAIT: on the last wait cycle, sample BUS_DATA into the data register -> WRITE.
  - WRITE: one cycle; BUS_ADDR=dst, BUS_WE=1, BUS_DATA=data register -> NEXT.
  - NEXT: src+=1, dst+=1 (8-bit wrap, 8'hFF->8'h00); remaining-=1. If remaining==0 -> FIN, else -> RD_ADDR. Bus is held with BUS_WE=0 in this state; no REQ release between bytes.
  - FIN: BUS_REQ=0, release bus, DONE=1 for one cycle, BUSY=0 -> IDLE.
- Throughput: RD_LAT+2 cycles per byte once granted. Latency from grant to the first write strobe is RD_LAT+1 cycles.
- Grant loss: BUS_GNT low in any owned state other than REQ:
  - Release drivers in that same cycle (combinational on own).
  - Set ERR and go to FIN. The partially read byte is not written.
- START while BUSY: ignored, with no effect on latched values.
- RESET mid-transfer: returns to IDLE next edge. Drivers are released and no DONE pulse is issued.
- Overlap of source and destination ranges is not checked; the copy is strictly ascending.

Optional Feature:
- Macro: DMA_FILL_EN.
- Defined:
  - Adds input FILL (1) and input FILL_VAL (8), both sampled at START.
  - FILL=1 skips RD_ADDR/RD_WAIT and writes FILL_VAL to dst..dst+LEN-1 at 2 cycles per byte (WRITE, NEXT).
  - SRC_ADDR is ignored in fill mode.
- Undefined: ports absent; copy mode only.

Test Plan:
- Copy: RAM[0x10..0x13]={A1,B2,C3,D4}, START src=0x10 dst=0x40 LEN=4, GNT held -> RAM[0x40..0x43]={A1,B2,C3,D4}; DONE pulse after exactly 4*(RD_LAT+2)+1 cycles post-grant; ERR=0.
- LEN=0: START -> DONE pulses the next cycle; BUS_REQ never asserts; BUSY stays 0.
- Address wrap: src=0xFE dst=0x7E LEN=3 -> reads 0xFE, 0xFF, 0x00 and writes 0x7E, 0x7F, 0x80; check the write to 0x80 is not stored by the RAM (out of range).
- Grant loss: drop BUS_GNT during the 2nd byte's RD_WAIT -> BUS_ADDR/BUS_WE are Z in the same cycle; ERR=1; DONE pulses; only the 1st byte is written.
- RESET at the 2nd WRITE -> next cycle BUS_REQ=0, BUSY=0, bus Z, no DONE; a new START then copies correctly with ERR=0.
- DMA_FILL_EN: FILL=1, FILL_VAL=0x5A, dst=0x20, LEN=5 -> RAM[0x20..0x24]=0x5A; 2 cycles per byte; no read cycles on the bus.
